stage_ic: RTL

Complete stage sitting directly downstream of the execute stage. It accepts one `EX_IC_PACKET` per cycle into a small in-order completion queue. It drains one entry per cycle onto the common data bus (CDB) and into the ROB complete port, and the ROB side can apply backpressure. The stage also resolves the branch target and taken status that the ROB needs for mispredict recovery, and it is cleared entirely by `squash`.

---
 rtl/stage_ic_pkg.sv | 59 +++++
 rtl/stage_ic_queue.sv | 79 +++++++
 rtl/stage_ic.sv | 88 ++++++++
 3 files changed

// File: rtl/stage_ic_pkg.sv
// Shared types for the complete stage: execute-to-complete packet, queue entry, CDB and ROB packets.
// Optional same-cycle bypass in stage_ic is enabled by defining IC_BYPASS_EN.
package stage_ic_pkg;

    localparam int IC_DEPTH_DEF = 4;
    localparam int PHYS_REG_W   = 6;
    localparam int ROB_IDX_W    = 5;
    localparam int XLEN         = 32;

    typedef struct packed {
        logic                  valid;
        logic [PHYS_REG_W-1:0] phys_reg;
    } PHYS_TAG;

    typedef struct packed {
        PHYS_TAG tag;
        logic    valid;
    } CDB_PACKET;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic                 complete;
        logic                 take_branch;
        logic [XLEN-1:0]      branch_target;
        logic                 halt;
        logic                 illegal;
    } IC_ROB_PACKET;

    typedef struct packed {
        logic                 valid;
        PHYS_TAG              dest_tag;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [XLEN-1:0]      result;
        logic [XLEN-1:0]      npc;
        logic                 take_branch;
        logic                 halt;
        logic                 illegal;
    } EX_IC_PACKET;

    typedef struct packed {
        PHYS_TAG              dest_tag;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [XLEN-1:0]      result;
        logic [XLEN-1:0]      npc;
        logic                 take_branch;
        logic                 halt;
        logic                 illegal;
    } IC_ENTRY;

    function automatic logic [XLEN-1:0] resolve_target(input IC_ENTRY e);
        return e.take_branch ? e.result : e.npc;
    endfunction

    // Illegal results and writes to p0 must never wake consumers.
    function automatic logic drives_cdb(input IC_ENTRY e);
        return e.dest_tag.valid && (e.dest_tag.phys_reg != '0) && !e.illegal;
    endfunction

endpackage

// File: rtl/stage_ic_queue.sv
// In-order circular completion buffer with push, pop, clear, occupancy count and a head read port.
module ic_queue
    import stage_ic_pkg::*;
#(
    parameter int DEPTH = IC_DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  IC_ENTRY          push_data,
    input  logic             pop,
    output IC_ENTRY          head_data,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    IC_ENTRY          mem_q [DEPTH];
    IC_ENTRY          mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Next-state for pointers, count and storage; clear wins over push and pop.
    always_comb begin
        mem_d     = mem_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        push_ok_s = push && (count_q != FULL_CNT);
        pop_ok_s  = pop && (count_q != '0);
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok_s) begin
                mem_d[tail_q] = push_data;
                tail_d        = tail_q + 1'b1;
            end else begin
                tail_d = tail_q;
            end
            if (pop_ok_s) begin
                head_d = head_q + 1'b1;
            end else begin
                head_d = head_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State register; reset also scrubs stored entries.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q   <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_data = mem_q[head_q];
    assign count     = count_q;

endmodule

// File: rtl/stage_ic.sv
// Complete stage: queues execute results in order and drains one per cycle to the CDB and ROB.
// Define IC_BYPASS_EN to present a result in its arrival cycle when the queue is empty.
module stage_ic
    import stage_ic_pkg::*;
#(
    parameter int IC_DEPTH = IC_DEPTH_DEF,
    localparam int CNT_W = $clog2(IC_DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  EX_IC_PACKET      ex_ic_packet,
    input  logic             squash,
    input  logic             rob_stall,
    output logic             ic_ready,
    output CDB_PACKET        ic_cdb_packet,
    output IC_ROB_PACKET     ic_rob_packet,
    output logic [CNT_W-1:0] ic_count
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(IC_DEPTH);

    IC_ENTRY          in_entry_s;
    IC_ENTRY          head_entry_s;
    IC_ENTRY          sel_entry_s;
    logic [CNT_W-1:0] count_s;
    logic             flush_s;
    logic             not_empty_s;
    logic             bypass_s;
    logic             push_s;
    logic             pop_s;
    logic             present_s;

    ic_queue #(.DEPTH(IC_DEPTH)) u_queue (
        .clock     (clock),
        .reset     (reset),
        .clear     (squash),
        .push      (push_s),
        .push_data (in_entry_s),
        .pop       (pop_s),
        .head_data (head_entry_s),
        .count     (count_s)
    );

    // Entry packing and push/pop/bypass qualification; ready ignores a same-cycle pop.
    always_comb begin
        in_entry_s.dest_tag    = ex_ic_packet.dest_tag;
        in_entry_s.rob_idx     = ex_ic_packet.rob_idx;
        in_entry_s.result      = ex_ic_packet.result;
        in_entry_s.npc         = ex_ic_packet.npc;
        in_entry_s.take_branch = ex_ic_packet.take_branch;
        in_entry_s.halt        = ex_ic_packet.halt;
        in_entry_s.illegal     = ex_ic_packet.illegal;

        flush_s     = squash || reset;
        not_empty_s = (count_s != '0);
        ic_ready    = (count_s < FULL_CNT);
`ifdef IC_BYPASS_EN
        bypass_s    = !not_empty_s && ex_ic_packet.valid && !rob_stall && !flush_s;
`else
        bypass_s    = 1'b0;
`endif
        push_s      = ex_ic_packet.valid && ic_ready && !flush_s && !bypass_s;
        pop_s       = not_empty_s && !rob_stall && !flush_s;
        present_s   = pop_s || bypass_s;
        sel_entry_s = bypass_s ? in_entry_s : head_entry_s;
        ic_count    = count_s;
    end

    // Head (or bypassed) presentation; everything reads zero when nothing completes.
    always_comb begin
        ic_cdb_packet = '0;
        ic_rob_packet = '0;
        if (present_s) begin
            ic_rob_packet.rob_idx       = sel_entry_s.rob_idx;
            ic_rob_packet.complete      = 1'b1;
            ic_rob_packet.take_branch   = sel_entry_s.take_branch;
            ic_rob_packet.branch_target = resolve_target(sel_entry_s);
            ic_rob_packet.halt          = sel_entry_s.halt;
            ic_rob_packet.illegal       = sel_entry_s.illegal;
            ic_cdb_packet.tag           = sel_entry_s.dest_tag;
            ic_cdb_packet.valid         = drives_cdb(sel_entry_s);
        end else begin
            ic_cdb_packet = '0;
            ic_rob_packet = '0;
        end
    end

endmodule
